bus_fabric: RTL and testbench

- Parametrised single-master bus interconnect that replaces the fixed combinational address decode in the SoC top.
- Decodes CPU addresses into N_SLAVES base/mask regions and runs a req/ready handshake with per-slave wait states.
- Aborts hung accesses with a timeout and reports unmapped or timed-out accesses through sticky error registers and an interrupt line.
- Sits between the cpu and the ram/uart/interrupt_ctrl peripherals; o_err_irq feeds an interrupt_ctrl line.

---
 rtl/bus_fabric_if.sv | 32 +++
 rtl/bus_fabric.sv | 164 ++++++++++++++++
 tb/tb_bus_fabric.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// CPU-side and peripheral-side signal bundle for bus_fabric.
// The fabric uses the slave modport; a CPU/testbench driver uses the master modport.
interface bus_fabric_if #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
);
  logic                         i_m_req;
  logic                         i_m_we;
  logic [ADDR_W-1:0]            i_m_addr;
  logic [DATA_W-1:0]            i_m_wdata;
  logic                         o_m_ready;
  logic                         o_m_err;
  logic [DATA_W-1:0]            o_m_rdata;
  logic [N_SLAVES-1:0]          o_s_sel;
  logic                         o_s_we;
  logic [ADDR_W-1:0]            o_s_addr;
  logic [DATA_W-1:0]            o_s_wdata;
  logic [N_SLAVES-1:0]          i_s_ready;
  logic [N_SLAVES*DATA_W-1:0]   i_s_rdata;
  logic                         o_err_irq;

  modport slave (
    input  i_m_req, i_m_we, i_m_addr, i_m_wdata, i_s_ready, i_s_rdata,
    output o_m_ready, o_m_err, o_m_rdata, o_s_sel, o_s_we, o_s_addr, o_s_wdata, o_err_irq
  );

  modport master (
    output i_m_req, i_m_we, i_m_addr, i_m_wdata, i_s_ready, i_s_rdata,
    input  o_m_ready, o_m_err, o_m_rdata, o_s_sel, o_s_we, o_s_addr, o_s_wdata, o_err_irq
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-master interconnect: base/mask region decode, wait-state handshake with timeout,
// and sticky fault registers (fault address + flags) exposed at ERR_ADDR/ERR_ADDR+1.
module bus_fabric #(
  parameter int                         N_SLAVES = 4,
  parameter int                         ADDR_W   = 16,
  parameter int                         DATA_W   = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {16'h0410, 16'h0400, 16'h0000, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {16'hFFFF, 16'hFFFE, 16'hFC00, 16'h0000},
  parameter int                         TIMEOUT  = 255,
  parameter logic [ADDR_W-1:0]          ERR_ADDR = 16'h0420
) (
  input logic         i_clk,
  input logic         i_reset_n,
  bus_fabric_if.slave bus
);
  localparam int                CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO    = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ERR_HI = ERR_ADDR + 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [N_SLAVES-1:0] s_sel_reg;
  logic                s_we_reg;
  logic [ADDR_W-1:0]   s_addr_reg;
  logic [DATA_W-1:0]   s_wdata_reg;
  logic                m_ready_reg;
  logic                m_err_reg;
  logic [DATA_W-1:0]   m_rdata_reg;
  logic                tmo_flag_reg;
  logic                unm_flag_reg;
  logic [ADDR_W-1:0]   fault_addr_reg;
  logic                irq_reg;

  logic [N_SLAVES-1:0] hit;
  logic [N_SLAVES-1:0] sel_dec;
  logic [DATA_W-1:0]   rd_mux;
  logic                ready_sel;
  logic                is_err_reg;
  logic                no_fault;

  // A zero mask disables the region so it can never match.
  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_hit
      assign hit[gi] = (SLV_MASK[gi*ADDR_W +: ADDR_W] != '0) &&
                       ((bus.i_m_addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    sel_dec = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_dec    = '0;
        sel_dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel_reg[i]) rd_mux = bus.i_s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ready_sel  = |(bus.i_s_ready & s_sel_reg);
  assign is_err_reg = (bus.i_m_addr == ERR_ADDR) || (bus.i_m_addr == ERR_HI);
  assign no_fault   = !tmo_flag_reg && !unm_flag_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      s_sel_reg      <= '0;
      s_we_reg       <= 1'b0;
      s_addr_reg     <= '0;
      s_wdata_reg    <= '0;
      m_ready_reg    <= 1'b0;
      m_err_reg      <= 1'b0;
      m_rdata_reg    <= '0;
      tmo_flag_reg   <= 1'b0;
      unm_flag_reg   <= 1'b0;
      fault_addr_reg <= '0;
      irq_reg        <= 1'b0;
    end else begin
      m_ready_reg <= 1'b0;
      irq_reg     <= tmo_flag_reg | unm_flag_reg;
      case (state_reg)
        IDLE: begin
          if (bus.i_m_req) begin
            s_addr_reg  <= bus.i_m_addr;
            s_wdata_reg <= bus.i_m_wdata;
            if (is_err_reg) begin
              state_reg   <= RESP;
              m_ready_reg <= 1'b1;
              m_err_reg   <= 1'b0;
              if (bus.i_m_we) begin
                m_rdata_reg <= '0;
                if (bus.i_m_addr == ERR_HI) begin
                  tmo_flag_reg <= 1'b0;
                  unm_flag_reg <= 1'b0;
                end
              end else if (bus.i_m_addr == ERR_ADDR) begin
                m_rdata_reg <= DATA_W'(fault_addr_reg);
              end else begin
                m_rdata_reg <= DATA_W'({tmo_flag_reg, unm_flag_reg});
              end
            end else if (|sel_dec) begin
              // Write enable only reaches the bus when a slave is actually selected.
              state_reg <= ACCESS;
              s_sel_reg <= sel_dec;
              s_we_reg  <= bus.i_m_we;
              cnt_reg   <= '0;
            end else begin
              state_reg    <= RESP;
              m_ready_reg  <= 1'b1;
              m_err_reg    <= 1'b1;
              m_rdata_reg  <= '1;
              unm_flag_reg <= 1'b1;
              if (no_fault) fault_addr_reg <= bus.i_m_addr;
            end
          end
        end
        ACCESS: begin
          if (ready_sel) begin
            state_reg   <= RESP;
            m_ready_reg <= 1'b1;
            m_err_reg   <= 1'b0;
            m_rdata_reg <= s_we_reg ? '0 : rd_mux;
            s_sel_reg   <= '0;
            s_we_reg    <= 1'b0;
          end else if (cnt_reg == TMO) begin
            state_reg    <= RESP;
            m_ready_reg  <= 1'b1;
            m_err_reg    <= 1'b1;
            m_rdata_reg  <= '1;
            s_sel_reg    <= '0;
            s_we_reg     <= 1'b0;
            tmo_flag_reg <= 1'b1;
            if (no_fault) fault_addr_reg <= s_addr_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_m_ready = m_ready_reg;
  assign bus.o_m_err   = m_err_reg;
  assign bus.o_m_rdata = m_rdata_reg;
  assign bus.o_s_sel   = s_sel_reg;
  assign bus.o_s_we    = s_we_reg;
  assign bus.o_s_addr  = s_addr_reg;
  assign bus.o_s_wdata = s_wdata_reg;
  assign bus.o_err_irq = irq_reg;
endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: main instance (TIMEOUT=4, slave 3 mapped at 0x1xxx)
// plus a two-slave instance whose regions overlap at 0x0400.
module tb_bus_fabric;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_fabric_if #(.N_SLAVES(4), .ADDR_W(16), .DATA_W(16)) bif ();
  bus_fabric_if #(.N_SLAVES(2), .ADDR_W(16), .DATA_W(16)) bif2 ();

  bus_fabric #(
    .N_SLAVES(4), .ADDR_W(16), .DATA_W(16),
    .SLV_BASE({16'h1000, 16'h0410, 16'h0400, 16'h0000}),
    .SLV_MASK({16'hF000, 16'hFFFF, 16'hFFFE, 16'hFC00}),
    .TIMEOUT(4), .ERR_ADDR(16'h0420)
  ) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bif));

  bus_fabric #(
    .N_SLAVES(2), .ADDR_W(16), .DATA_W(16),
    .SLV_BASE({16'h0400, 16'h0000}),
    .SLV_MASK({16'hFFFE, 16'hF800}),
    .TIMEOUT(4), .ERR_ADDR(16'h0420)
  ) dut2 (.i_clk(clk), .i_reset_n(rst_n), .bus(bif2));

  // Slave models: 0 always ready, 1 ready after 3 wait states, 2 and 3 never ready.
  int   s1_cnt = 0;
  int   s1_commits = 0;
  logic s1_ready;
  assign s1_ready       = bif.o_s_sel[1] && (s1_cnt == 3);
  assign bif.i_s_ready  = {1'b0, 1'b0, s1_ready, 1'b1};
  assign bif.i_s_rdata  = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};
  assign bif2.i_s_ready = 2'b11;
  assign bif2.i_s_rdata = {16'h5555, 16'hAAAA};

  always @(posedge clk) begin
    s1_cnt <= bif.o_s_sel[1] ? s1_cnt + 1 : 0;
    if (bif.o_s_sel[1] && s1_ready && bif.o_s_we) s1_commits <= s1_commits + 1;
  end

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_pop(input int d, input exp_t e, input logic err, input logic [15:0] rdata);
    chk($sformatf("dut%0d_err", d), {31'd0, err}, {31'd0, e.err});
    if (e.chk_rd) chk($sformatf("dut%0d_rdata", d), {16'd0, rdata}, {16'd0, e.rdata});
    chk($sformatf("dut%0d_ready_cycle", d), cyc, e.cyc);
    $display("txn dut%0d err=%0b rdata=%04h cycle=%0d", d, err, rdata, cyc);
  endtask

  always @(negedge clk) begin
    if (bif.o_m_ready) begin
      if (q0.size() == 0) chk("dut0_unexpected_ready", 32'd1, 32'd0);
      else mon_pop(0, q0.pop_front(), bif.o_m_err, bif.o_m_rdata);
    end
    if (bif2.o_m_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_ready", 32'd1, 32'd0);
      else mon_pop(1, q1.pop_front(), bif2.o_m_err, bif2.o_m_rdata);
    end
  end

  // Issues one request; returns at the negedge of cycle 1 with req already dropped.
  task automatic start(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic exp_err, input logic [15:0] exp_rd, input bit chk_rd, input int lat);
    exp_t e;
    @(negedge clk);
    e.err = exp_err; e.rdata = exp_rd; e.chk_rd = chk_rd; e.cyc = cyc + lat;
    if (d == 0) begin
      q0.push_back(e);
      bif.i_m_req = 1'b1; bif.i_m_we = we; bif.i_m_addr = addr; bif.i_m_wdata = wdata;
    end else begin
      q1.push_back(e);
      bif2.i_m_req = 1'b1; bif2.i_m_we = we; bif2.i_m_addr = addr; bif2.i_m_wdata = wdata;
    end
    @(negedge clk);
    bif.i_m_req = 1'b0;
    bif2.i_m_req = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 40; i++) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) return;
      @(negedge clk);
      #1;
    end
    chk($sformatf("dut%0d_response_timeout", d), 32'd1, 32'd0);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic txn(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic exp_err, input logic [15:0] exp_rd, input bit chk_rd, input int lat);
    start(d, we, addr, wdata, exp_err, exp_rd, chk_rd, lat);
    wait_done(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.i_m_req = 0; bif.i_m_we = 0; bif.i_m_addr = 0; bif.i_m_wdata = 0;
    bif2.i_m_req = 0; bif2.i_m_we = 0; bif2.i_m_addr = 0; bif2.i_m_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", {31'd0, bif.o_m_ready}, 32'd0);
    chk("rst_s_sel", {28'd0, bif.o_s_sel}, 32'd0);
    chk("rst_m_rdata", {16'd0, bif.o_m_rdata}, 32'd0);
    chk("rst_irq", {31'd0, bif.o_err_irq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait read of slave 0.
    start(0, 1'b0, 16'h0123, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 2);
    chk("rd0_sel_c1", {28'd0, bif.o_s_sel}, 32'h1);
    wait_done(0);

    // Slave 1 write with 3 wait states.
    start(0, 1'b1, 16'h0400, 16'h0041, 1'b0, 16'h0000, 1'b1, 5);
    chk("wr1_sel_c1", {28'd0, bif.o_s_sel}, 32'h2);
    chk("wr1_we_c1", {31'd0, bif.o_s_we}, 32'd1);
    chk("wr1_addr_c1", {16'd0, bif.o_s_addr}, 32'h0400);
    chk("wr1_wdata_c1", {16'd0, bif.o_s_wdata}, 32'h0041);
    repeat (3) @(negedge clk);
    chk("wr1_sel_c4", {28'd0, bif.o_s_sel}, 32'h2);
    wait_done(0);
    chk("wr1_commits", s1_commits, 1);

    // Slave 2 never ready: timeout at cycle TIMEOUT+2.
    start(0, 1'b0, 16'h0410, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 6);
    chk("tmo_sel_c1", {28'd0, bif.o_s_sel}, 32'h4);
    repeat (4) @(negedge clk);
    chk("tmo_sel_c5", {28'd0, bif.o_s_sel}, 32'h4);
    wait_done(0);
    chk("tmo_sel_after", {28'd0, bif.o_s_sel}, 32'h0);
    txn(0, 1'b0, 16'h0421, 16'h0000, 1'b0, 16'h0002, 1'b1, 1);
    txn(0, 1'b0, 16'h0420, 16'h0000, 1'b0, 16'h0410, 1'b1, 1);
    chk("tmo_irq", {31'd0, bif.o_err_irq}, 32'd1);
    txn(0, 1'b1, 16'h0421, 16'h0000, 1'b0, 16'h0000, 1'b0, 1);
    repeat (2) @(negedge clk);
    chk("tmo_irq_cleared", {31'd0, bif.o_err_irq}, 32'd0);

    // Unmapped accesses: first fault address is kept.
    txn(0, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1);
    txn(0, 1'b0, 16'h9000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1);
    txn(0, 1'b0, 16'h0420, 16'h0000, 1'b0, 16'h8000, 1'b1, 1);
    txn(0, 1'b0, 16'h0421, 16'h0000, 1'b0, 16'h0001, 1'b1, 1);
    chk("unm_irq", {31'd0, bif.o_err_irq}, 32'd1);
    txn(0, 1'b1, 16'h0421, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1);
    repeat (2) @(negedge clk);
    chk("unm_irq_cleared", {31'd0, bif.o_err_irq}, 32'd0);
    txn(0, 1'b0, 16'h0421, 16'h0000, 1'b0, 16'h0000, 1'b1, 1);

    // Overlapping regions: lowest index wins.
    start(1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'hAAAA, 1'b1, 2);
    chk("ovl_sel_c1", {30'd0, bif2.o_s_sel}, 32'h1);
    wait_done(1);

    // Reset during a slave-3 wait: access is dropped without a response.
    start(0, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    chk("rstmid_sel_c1", {28'd0, bif.o_s_sel}, 32'h8);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sel_dropped", {28'd0, bif.o_s_sel}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    txn(0, 1'b0, 16'h0123, 16'h0000, 1'b0, 16'hBEEF, 1'b1, 2);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
